trng_arbiter: RTL and testbench
===============================

Name: trng_arbiter

Overview:
- Shares the single 32-bit TRNG word source between NUM_REQ requesters, e.g. the ChaCha20 key loader, the nonce loader and a reseed engine.
- Each requester uses the same level-request / ready-pulse handshake the key loader uses. The arbiter grants one requester per word, round-robin, and forwards that TRNG word to the granted requester only.
- It also detects TRNG stalls via a timeout and keeps a delivered-word counter for status.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = key loader.
- TIMEOUT_CYCLES, 1024, cycles in WAIT without trng_ready before a timeout fires (>=2).
- IDW, 2, width of requester index fields; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester level request; held until ready seen or abandoned.
- req_ready_o  out  NUM_REQ  one-cycle pulse to granted requester; data valid this cycle.
- req_data_o  out  32  TRNG word, broadcast; meaningful only with req_ready_o.
- grant_o  out  NUM_REQ  one-hot current grant, all-zero when none.
- trng_req_o  out  1  request to TRNG.
- trng_ready_i  in  1  TRNG word valid.
- trng_data_i  in  32  TRNG word.
- busy_o  out  1  high when state != IDLE.
- timeout_err_o  out  1  sticky timeout flag.
- err_id_o  out  IDW  requester index granted when the last timeout fired.
- err_clear_i  in  1  clears timeout_err_o.
- word_count_o  out  16  total words delivered; wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, rr pointer=0, timeout counter=0, timeout_err_o=0, err_id_o=0, word_count_o=0. All combinational outputs evaluate to 0.
- Combinational outputs:
  - trng_req_o = (state==WAIT).
  - req_ready_o[i] = (state==WAIT) & trng_ready_i & grant[i].
  - req_data_o = trng_data_i.
  - busy_o = (state!=IDLE).
- IDLE:
  - If any req_i is set, pick the first requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - Register grant to that requester (one-hot), clear the timeout counter, go to WAIT.
  - If no req_i is set, stay in IDLE.
- WAIT, checked in priority order:
  - (a) trng_ready_i=1: word is delivered this cycle; word_count += 1; rr pointer <= grant index + 1 (mod NUM_REQ); go to RELEASE.
  - (b) Else if req_i[grant] == 0 (requester abandoned): go to RELEASE; pointer advances; no count.
  - (c) Else if the timeout counter == TIMEOUT_CYCLES-1: timeout_err_o <= 1, err_id_o <= grant index; pointer advances; go to RELEASE.
  - (d) Else the timeout counter increments.
- RELEASE:
  - grant <= 0; go to IDLE unconditionally.
  - This 1-cycle gap lets the served requester drop req_i before re-arbitration.
  - Minimum cost is 3 cycles per word (IDLE, WAIT, RELEASE).
- trng_ready_i outside WAIT is ignored: no req_ready_o pulse, no count.
- If trng_ready_i and an abandon happen in the same WAIT cycle, delivery wins: the pulse is still issued and the word counted.
- Timeout flag:
  - err_clear_i clears timeout_err_o.
  - If a timeout fires in the same cycle as err_clear_i, the set wins.
  - err_id_o keeps its value until the next timeout.
- Requester indices >= NUM_REQ never exist. Unused high bits of IDW fields are 0.
- A reset in any state aborts immediately. No req_ready_o is issued for a word in flight.

Test Plan:
- Key-loader traffic: req_i=001 held; TRNG returns ready 2 cycles after each trng_req_o rises, 8 times, with data 0x1000_0000+n -> 8 req_ready_o[0] pulses carrying matching data; grant_o=001 in each WAIT; word_count_o=8; at most one pulse per 3-cycle window.
- Round robin: req_i=111 held, TRNG ready 1 cycle after request -> grant order 001, 010, 100, 001; no requester served twice before the others; each grant_o is one-hot with a 000 gap in RELEASE.
- Timeout: TIMEOUT_CYCLES=16, req_i=010, no trng_ready_i -> after 16 WAIT cycles timeout_err_o=1, err_id_o=1, grant_o=000 next cycle, word_count_o unchanged. Then err_clear_i pulse -> flag 0.
- Abandon and stray ready: req_i[0] drops mid-WAIT -> RELEASE, no pulse. A trng_ready_i pulse during IDLE or RELEASE -> no req_ready_o and no count change.
- Simultaneous events: ready and abandon in the same cycle -> pulse issued, count +1. Timeout coincident with err_clear_i -> timeout_err_o=1.
- Reset mid-WAIT with req_i=100 -> all outputs 0 asynchronously. After release, arbitration restarts from pointer 0 (with req_i=101, grant_o=001 first).

Source files
------------

// File: rtl/trng_arbiter.sv
// Round-robin arbiter sharing one TRNG word source between NUM_REQ requesters,
// with stall timeout detection and a delivered-word counter.
module trng_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned IDW            = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic [31:0]        req_data_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               trng_req_o,
  input  logic               trng_ready_i,
  input  logic [31:0]        trng_data_i,
  output logic               busy_o,
  output logic               timeout_err_o,
  output logic [IDW-1:0]     err_id_o,
  input  logic               err_clear_i,
  output logic [15:0]        word_count_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RELEASE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     gidx_q, gidx_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               err_q, err_d;
  logic [IDW-1:0]     err_id_q, err_id_d;
  logic [15:0]        wcnt_q, wcnt_d;

  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;
  logic [IDW-1:0]     nxt_ptr;

  // First requesting index at or after the round-robin pointer.
  always_comb begin
    int unsigned j;
    j          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_valid && req_i[IDW'(j)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(j);
      end
    end
  end

  assign nxt_ptr = (gidx_q == IDW'(NUM_REQ - 1)) ? '0 : gidx_q + IDW'(1);

  assign trng_req_o    = (state_q == ST_WAIT);
  assign req_ready_o   = (state_q == ST_WAIT && trng_ready_i) ? grant_q : '0;
  assign req_data_o    = trng_data_i;
  assign busy_o        = (state_q != ST_IDLE);
  assign grant_o       = grant_q;
  assign timeout_err_o = err_q;
  assign err_id_o      = err_id_q;
  assign word_count_o  = wcnt_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    tcnt_d   = tcnt_q;
    wcnt_d   = wcnt_q;
    err_id_d = err_id_q;
    err_d    = err_q & ~err_clear_i;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Delivery beats abandon, abandon beats timeout.
        if (trng_ready_i) begin
          wcnt_d  = wcnt_q + 16'd1;
          rr_d    = nxt_ptr;
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (!req_i[gidx_q]) begin
          rr_d    = nxt_ptr;
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          err_id_d = gidx_q;
          rr_d     = nxt_ptr;
          grant_d  = '0;
          state_d  = ST_RELEASE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
      wcnt_q   <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_trng_arbiter.sv
// Directed bench for trng_arbiter: scoreboarded deliveries, round robin,
// timeout, abandon, stray ready and asynchronous reset.
module tb_trng_arbiter;

  localparam int unsigned NR = 3;

  typedef struct packed {
    logic [NR-1:0] mask;
    logic [31:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_i;
  logic [NR-1:0] req_ready_o;
  logic [31:0]   req_data_o;
  logic [NR-1:0] grant_o;
  logic          trng_req_o;
  logic          trng_ready_i;
  logic [31:0]   trng_data_i;
  logic          busy_o;
  logic          timeout_err_o;
  logic [1:0]    err_id_o;
  logic          err_clear_i;
  logic [15:0]   word_count_o;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   cyc = 0;
  int   last_pulse = -100;
  int   ptr;
  int   idx;

  trng_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_ready_o(req_ready_o),
    .req_data_o(req_data_o), .grant_o(grant_o), .trng_req_o(trng_req_o),
    .trng_ready_i(trng_ready_i), .trng_data_i(trng_data_i), .busy_o(busy_o),
    .timeout_err_o(timeout_err_o), .err_id_o(err_id_o),
    .err_clear_i(err_clear_i), .word_count_o(word_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (trng_req_o !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 32'(trng_req_o), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_treq"}, 32'(trng_req_o), 32'd0);
    chk({tag, "_rdy"}, 32'(req_ready_o), 32'd0);
    chk({tag, "_err"}, 32'(timeout_err_o), 32'd0);
    chk({tag, "_errid"}, 32'(err_id_o), 32'd0);
    chk({tag, "_cnt"}, 32'(word_count_o), 32'd0);
  endtask

  task automatic deliver(input logic [31:0] d, input logic [NR-1:0] mask);
    exp_t e;
    e.mask = mask;
    e.data = d;
    exp_q.push_back(e);
    trng_ready_i = 1'b1;
    trng_data_i  = d;
    tick();
    trng_ready_i = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (grant_o !== 3'b000)
      chk("grant_onehot", 32'($onehot(grant_o)), 32'd1);
    if (req_ready_o !== 3'b000) begin
      exp_t e;
      chk("pulse_gap_ge3", 32'(cyc - last_pulse >= 3), 32'd1);
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        chk("stray_pulse", 32'(req_ready_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_mask", 32'(req_ready_o), 32'(e.mask));
        chk("pulse_data", req_data_o, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_i = '0; trng_ready_i = 1'b0; trng_data_i = '0; err_clear_i = 1'b0;
    tick(); tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Key loader stream.
    req_i = 3'b001;
    for (int n = 0; n < 8; n++) begin
      wait_req("key_wait");
      chk("key_grant", 32'(grant_o), 32'd1);
      tick(); tick();
      deliver(32'h1000_0000 + 32'(n), 3'b001);
      if (n == 7) req_i = 3'b000;
    end
    tick();
    chk("key_count", 32'(word_count_o), 32'd8);

    // Restart from pointer 0 for the round-robin pass.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ptr = 0;
    req_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_req("rr_wait");
      idx = -1;
      for (int m = NR - 1; m >= 0; m--) if (req_i[(ptr + m) % NR]) idx = (ptr + m) % NR;
      chk("rr_grant", 32'(grant_o), 32'(3'b001 << idx));
      tick();
      deliver(32'hA5A5_0000 + 32'(k), 3'(3'b001 << idx));
      ptr = (idx + 1) % NR;
      chk("rr_gap_grant", 32'(grant_o), 32'd0);
      chk("rr_gap_busy", 32'(busy_o), 32'd1);
      if (k == 3) req_i = 3'b000;
    end

    // Stray ready in RELEASE and then IDLE.
    trng_ready_i = 1'b1; trng_data_i = 32'hDEAD_BEEF;
    chk("stray_release_rdy", 32'(req_ready_o), 32'd0);
    tick();
    chk("stray_idle_rdy", 32'(req_ready_o), 32'd0);
    tick();
    trng_ready_i = 1'b0;
    chk("stray_count", 32'(word_count_o), 32'd4);

    // Abandon mid-WAIT.
    req_i = 3'b001;
    wait_req("abandon_wait");
    tick();
    req_i = 3'b000;
    tick();
    chk("abandon_grant", 32'(grant_o), 32'd0);
    chk("abandon_busy", 32'(busy_o), 32'd1);
    chk("abandon_count", 32'(word_count_o), 32'd4);
    tick();

    // Ready and abandon in the same cycle: delivery wins.
    req_i = 3'b001;
    wait_req("simul_wait");
    req_i = 3'b000;
    deliver(32'h5151_5151, 3'b001);
    chk("simul_count", 32'(word_count_o), 32'd5);
    tick();

    // Timeout on requester 1.
    req_i = 3'b010;
    wait_req("to_wait");
    chk("to_grant", 32'(grant_o), 32'd2);
    for (int n = 0; n < 15; n++) tick();
    chk("to_not_yet", 32'(timeout_err_o), 32'd0);
    chk("to_still_wait", 32'(trng_req_o), 32'd1);
    tick();
    chk("to_err", 32'(timeout_err_o), 32'd1);
    chk("to_errid", 32'(err_id_o), 32'd1);
    chk("to_grant_clr", 32'(grant_o), 32'd0);
    chk("to_count", 32'(word_count_o), 32'd5);
    err_clear_i = 1'b1; tick(); err_clear_i = 1'b0;
    chk("clear_err", 32'(timeout_err_o), 32'd0);
    chk("clear_errid_kept", 32'(err_id_o), 32'd1);

    // Second timeout coincident with err_clear_i: set wins.
    wait_req("to2_wait");
    for (int n = 0; n < 15; n++) tick();
    err_clear_i = 1'b1; tick(); err_clear_i = 1'b0;
    chk("to2_set_wins", 32'(timeout_err_o), 32'd1);
    chk("to2_errid", 32'(err_id_o), 32'd1);
    req_i = 3'b000;
    tick(); tick();

    // Asynchronous reset mid-WAIT.
    req_i = 3'b100;
    wait_req("rst_wait");
    chk("rst_pre_grant", 32'(grant_o), 32'd4);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("async_rst");
    req_i = 3'b101;
    tick();
    rst = 1'b0;
    wait_req("post_rst_wait");
    chk("post_rst_grant", 32'(grant_o), 32'd1);
    req_i = 3'b000;
    tick(); tick(); tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
